// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with asynchronous reads plus an MMIO window (timer, LED latch).
// Define DMEM_TIMER_EN to build the timer registers (CTRL/LOAD/COUNT/STATUS) and timer_irq.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        timer_irq,
  output logic [15:0] led
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  localparam logic [5:0] SEL_CTRL   = 6'h00;
  localparam logic [5:0] SEL_LOAD   = 6'h01;
  localparam logic [5:0] SEL_COUNT  = 6'h02;
  localparam logic [5:0] SEL_STATUS = 6'h03;
  localparam logic [5:0] SEL_LED    = 6'h04;

  logic          mmio_hit;
  logic          ram_hit;
  logic          mmio_wr;
  logic [AW-1:0] ram_idx;
  logic [5:0]    reg_sel;
  logic [31:0]   ram [DEPTH_WORDS];

  // Word access only: the byte-lane bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, Addr_in[1:0]};

  assign mmio_hit = (Addr_in[31:8] == MMIO_BASE[31:8]);
  assign ram_hit  = !mmio_hit && (Addr_in[31:2] < DEPTH_LIM);
  assign mmio_wr  = mem_w && mmio_hit;
  assign ram_idx  = Addr_in[AW+1:2];
  assign reg_sel  = Addr_in[7:2];

  // RAM is not reset, so a write presented during reset still lands.
  always_ff @(posedge clk) begin
    if (mem_w && ram_hit) begin
      ram[ram_idx] <= Data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else if (mmio_wr && reg_sel == SEL_LED) begin
      led <= Data_in[15:0];
    end
  end

`ifdef DMEM_TIMER_EN
  logic [2:0]  ctrl;        // {IE, AUTO, EN}
  logic [31:0] load;
  logic [31:0] count;
  logic        exp_flag;
  logic [31:0] count_step;
  logic        expire;
  logic        wr_count;

  assign wr_count = mmio_wr && (reg_sel == SEL_COUNT);

  always_comb begin
    count_step = count;
    expire     = 1'b0;
    if (ctrl[0]) begin
      if (count == 32'd0) begin
        count_step = ctrl[1] ? load : 32'd0;
      end else begin
        count_step = count - 32'd1;
        expire     = (count == 32'd1);
      end
    end
  end

  // A CPU write to COUNT overrides the tick and suppresses that tick's expiry;
  // an expiry beats a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
    end else begin
      if (mmio_wr && reg_sel == SEL_CTRL) ctrl <= Data_in[2:0];
      if (mmio_wr && reg_sel == SEL_LOAD) load <= Data_in;
      count <= wr_count ? Data_in : count_step;
      if (expire && !wr_count) begin
        exp_flag <= 1'b1;
      end else if (mmio_wr && reg_sel == SEL_STATUS && Data_in[0]) begin
        exp_flag <= 1'b0;
      end
    end
  end

  assign timer_irq = exp_flag & ctrl[2];
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    Data_out = '0;
    if (mmio_hit) begin
      case (reg_sel)
`ifdef DMEM_TIMER_EN
        SEL_CTRL:   Data_out = {29'd0, ctrl};
        SEL_LOAD:   Data_out = load;
        SEL_COUNT:  Data_out = count;
        SEL_STATUS: Data_out = {31'd0, exp_flag};
`endif
        SEL_LED:    Data_out = {16'd0, led};
        default:    Data_out = '0;
      endcase
    end else if (ram_hit) begin
      Data_out = ram[ram_idx];
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle MIPS core: it answers the core's data port (address, write data, write strobe) with word RAM plus a small memory-mapped register window (timer, LED latch). Reads are asynchronous so a load completes within the core's single cycle. Writes commit on the clock edge. It sits between the CPU top level and the board I/O, and drives a timer interrupt line and an LED output.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `MMIO_BASE`, 32'h0000_FF00: base of the register window; bits [7:0] must be 0.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_w` in 1: write strobe from the core.
- `Addr_in` in 32: byte address from the core; bits [1:0] ignored (word access only).
- `Data_in` in 32: write data from the core.
- `Data_out` out 32: read data to the core; combinational.
- `timer_irq` out 1: timer interrupt request, level.
- `led` out 16: LED latch contents.

## Operation
- Decode:
  - MMIO hit when `Addr_in[31:8] == MMIO_BASE[31:8]`.
  - Otherwise RAM hit when `Addr_in[31:2] < DEPTH_WORDS`.
  - Otherwise unmapped: reads return 0, writes ignored.
- RAM:
  - Indexed by `Addr_in[log2(DEPTH_WORDS)+1:2]`.
  - Written when `mem_w` is high and the address is a RAM hit.
  - Not cleared by reset; contents are undefined until written.
- MMIO registers (offset = `Addr_in[7:0]`):
  - 0x00 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable). Other bits read 0.
  - 0x04 LOAD, R/W: 32-bit reload value.
  - 0x08 COUNT, R/W: current count. A write loads COUNT directly.
  - 0x0C STATUS, R/W1C: bit0 EXP (expired). Writing 1 clears it; writing 0 has no effect.
  - 0x10 LED, R/W: bits [15:0] drive `led`. Upper bits read 0.
  - Other offsets read 0; writes to them are ignored.
- Timer, each cycle with EN=1:
  - COUNT==0 and AUTO=1: COUNT <= LOAD.
  - COUNT==0 and AUTO=0: COUNT holds 0.
  - COUNT!=0: COUNT <= COUNT-1. If COUNT==1, also set EXP.
  - With EN=0, COUNT holds.
- `timer_irq` = EXP & IE.
- Simultaneous events:
  - A CPU write to COUNT in the same cycle as a decrement or reload: the write wins, and EXP is not set by that cycle's decrement.
  - A W1C clear of EXP in the same cycle as an expiry: set wins, so EXP stays 1.
  - A write to CTRL takes effect for the timer from the following cycle.

## Timing
- Read latency 0: `Data_out` follows `Addr_in` and current register/RAM state combinationally in the same cycle.
- Write latency 1: visible to reads from the cycle after the `mem_w` edge.
- A read of an address being written in the same cycle returns the old value.
- Reset values (clocked by `reset`=1 at an edge):
  - CTRL, LOAD, COUNT, STATUS, LED all 0.
  - `timer_irq` 0, `led` 0.
  - `Data_out` reflects those values combinationally; it is 0 for MMIO reads and for unmapped addresses.
- Reset mid-count: the timer stops at the next edge with COUNT=0 and EXP=0. A pending irq drops in the cycle after that edge.
- `mem_w` asserted during `reset`: reset wins for MMIO; RAM write is still performed.
- Expiry period:
  - AUTO=1, LOAD=N≥1, running from COUNT=N: EXP sets N cycles after the first enabled edge. Subsequent expiries occur every N+1 cycles (reload cycle included).
  - LOAD=0 with AUTO=1: COUNT stays 0 and never expires.
- COUNT is 32-bit unsigned. It is never decremented below 0; there is no wrap.

## Configuration
- Macro `DMEM_TIMER_EN`.
  - Defined: the timer registers (CTRL, LOAD, COUNT, STATUS) and `timer_irq` logic are built as above.
  - Undefined: timer offsets 0x00–0x0C read 0 and ignore writes, `timer_irq` is tied to 0, and no timer flops are instantiated.
  - RAM and LED are identical in both builds.

## Test plan
- RAM round-trip: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF. Read 0x0000_1000 with DEPTH_WORDS=1024 -> 0.
- LED: write 0x1234_ABCD to 0xFF10 -> `led`=0xABCD next cycle, read returns 0x0000_ABCD. Assert `reset` -> `led`=0.
- One-shot timer: LOAD=3, COUNT=3, CTRL=0x5 -> EXP=1 and `timer_irq`=1 exactly 3 cycles after the CTRL write commits. COUNT then stays 0. Write 1 to 0xFF0C -> `timer_irq`=0.
- Auto-reload: LOAD=2, COUNT=2, CTRL=0x7 -> expiries at cycles 2, 5, 8 relative to start. COUNT sequence 2,1,0,2,1,0.
- Collisions:
  - Write COUNT=10 on the cycle COUNT==1 -> COUNT=10, EXP stays 0.
  - W1C to STATUS on an expiry cycle -> EXP=1.
- Macro off (`DMEM_TIMER_EN` undefined): write 0x7 to 0xFF00 and 5 to 0xFF08 -> both read 0, `timer_irq` stays 0 for 20 cycles, LED still functional.
